// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared widths and the writeback entry layout for the FP unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int c_FP32_W = 32;
    localparam int c_RD_W   = 5;

    typedef struct packed {
        logic [c_RD_W-1:0]   rd;
        logic [c_FP32_W-1:0] data;
    } fwb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Show-ahead synchronous FIFO with occupancy count output.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_pop    = pop && (r_count != '0);
    // A pop frees the head slot this same edge, so a push at full is safe.
    assign w_push   = push && ((r_count != c_FULL) || w_pop);
    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmul_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : fmul_wb_queue
// Description : Credit-gated issue and in-order writeback buffering around a
//               fixed-latency fmul pipeline without tag pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_wb_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RD_W  = c_RD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [c_FP32_W-1:0] issue_a,
    input  logic [c_FP32_W-1:0] issue_b,
    input  logic [RD_W-1:0]     issue_rd,
    output logic [c_FP32_W-1:0] mul_a,
    output logic [c_FP32_W-1:0] mul_b,
    output logic                mul_valid,
    input  logic [c_FP32_W-1:0] mul_result,
    input  logic                mul_out_valid,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [RD_W-1:0]     wb_rd,
    output logic [c_FP32_W-1:0] wb_data,
    output logic                err
);

    localparam int c_CRED_W  = $clog2(DEPTH + 1);
    localparam int c_ENTRY_W = RD_W + c_FP32_W;
    localparam logic [c_CRED_W-1:0] c_CRED_MAX = c_CRED_W'(DEPTH);

    logic [c_CRED_W-1:0] r_credits;
    logic [c_CRED_W-1:0] w_credits_nxt;
    logic                r_issue_ready;
    logic                r_mul_valid;
    logic [c_FP32_W-1:0] r_mul_a;
    logic [c_FP32_W-1:0] r_mul_b;
    logic                r_err;

    logic                w_issue_fire;
    logic                w_wb_fire;
    logic                w_wb_valid;
    logic [RD_W-1:0]     w_tag_head;
    logic [c_CRED_W-1:0] w_tag_count;
    logic                w_tag_avail;
    logic                w_res_push;
    logic [c_ENTRY_W-1:0] w_res_head;
    logic [c_CRED_W-1:0] w_res_count;

    assign w_issue_fire = issue_valid && r_issue_ready;
    assign w_wb_valid   = (w_res_count != '0);
    assign w_wb_fire    = w_wb_valid && wb_ready;
    assign w_tag_avail  = (w_tag_count != '0);
    assign w_res_push   = mul_out_valid && w_tag_avail;

    always_comb begin
        w_credits_nxt = r_credits;
        case ({w_issue_fire, w_wb_fire})
            2'b10:   w_credits_nxt = r_credits - c_CRED_W'(1);
            2'b01:   w_credits_nxt = r_credits + c_CRED_W'(1);
            default: w_credits_nxt = r_credits;
        endcase
    end

    // issue_ready is registered from next-state credits, so it never sees
    // issue_valid or wb_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits     <= c_CRED_MAX;
            r_issue_ready <= 1'b0;
            r_mul_valid   <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_err         <= 1'b0;
        end else begin
            r_credits     <= w_credits_nxt;
            r_issue_ready <= (w_credits_nxt != '0);
            r_mul_valid   <= w_issue_fire;
            if (w_issue_fire) begin
                r_mul_a <= issue_a;
                r_mul_b <= issue_b;
            end
            if (mul_out_valid && !w_tag_avail) begin
                r_err <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (RD_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_issue_fire),
        .push_data (issue_rd),
        .pop       (mul_out_valid),
        .pop_data  (w_tag_head),
        .count     (w_tag_count)
    );

    // Entry layout matches fwb_entry_t: rd in the upper bits, data below.
    sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_res_push),
        .push_data ({w_tag_head, mul_result}),
        .pop       (w_wb_fire),
        .pop_data  (w_res_head),
        .count     (w_res_count)
    );

    assign issue_ready = r_issue_ready;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_valid   = r_mul_valid;
    assign wb_valid    = w_wb_valid;
    assign wb_rd       = w_res_head[c_ENTRY_W-1 -: RD_W];
    assign wb_data     = w_res_head[c_FP32_W-1:0];
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fmul_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_wb_queue
// Description : Directed bench for fmul_wb_queue with a 3-cycle fmul stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_wb_queue;

    localparam int DEPTH = 4;
    localparam int RD_W  = 5;
    localparam int LAT   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [31:0]     issue_a = '0;
    logic [31:0]     issue_b = '0;
    logic [RD_W-1:0] issue_rd = '0;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic            mul_valid;
    logic [31:0]     mul_result;
    logic            mul_out_valid;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic            err;
    logic            force_ov = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fmul_wb_queue #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_a       (issue_a),
        .issue_b       (issue_b),
        .issue_rd      (issue_rd),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid     (mul_valid),
        .mul_result    (mul_result),
        .mul_out_valid (mul_out_valid),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .err           (err)
    );

    // Products of the operand pairs this bench uses, computed by hand.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
            {32'hC0000000, 32'h40800000}: return 32'hC1000000;
            {32'h00000000, 32'h40A00000}: return 32'h00000000;
            {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h40400000, 32'h40400000}: return 32'h41100000;
            {32'h40800000, 32'h40000000}: return 32'h41000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    logic [LAT-1:0] pv;
    logic [31:0]    pd [LAT];
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv <= {pv[LAT-2:0], mul_valid};
        end
        pd[0] <= fmul_ref(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign mul_out_valid = pv[LAT-1] | force_ov;
    assign mul_result    = pd[LAT-1];

    int cyc = 0;
    logic [RD_W+31:0] wbq [$];
    int fire_cyc_q [$];
    int issue_cyc_q [$];
    logic cred_bad = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && wb_valid && wb_ready) begin
            wbq.push_back({wb_rd, wb_data});
            fire_cyc_q.push_back(cyc);
        end
        if (!rst && issue_valid && issue_ready) issue_cyc_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if (!rst && (dut.r_credits > DEPTH)) cred_bad <= 1'b1;
    end

    typedef struct {
        logic [31:0]     a;
        logic [31:0]     b;
        logic [RD_W-1:0] rd;
        logic [31:0]     exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the fire.
    task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic [RD_W-1:0] rd);
        issue_valid = 1'b1;
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
        for (int k = 0; k < 100 && !issue_ready; k++) @(negedge clk);
        if (!issue_ready) check("issue_timeout", 32'(issue_ready), 32'd1);
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic wait_fires(input int target, input int bound);
        for (int k = 0; k < bound && wbq.size() < target; k++) @(negedge clk);
        check("wb_fire_count", 32'(wbq.size()), 32'(target));
    endtask

    task automatic check_entry(input string name, input int idx, input logic [RD_W-1:0] rd, input logic [31:0] data);
        logic [RD_W+31:0] e;
        e = (idx < wbq.size()) ? wbq[idx] : '1;
        check({name, "_rd"},   32'(e[RD_W+31:32]), 32'(rd));
        check({name, "_data"}, e[31:0], data);
    endtask

    int wb_base;
    int is_base;

    initial begin
        vecs[0] = '{32'h3FC00000, 32'h3FC00000, 5'd1,  32'h40100000};
        vecs[1] = '{32'hC0000000, 32'h40800000, 5'd2,  32'hC1000000};
        vecs[2] = '{32'h00000000, 32'h40A00000, 5'd3,  32'h00000000};
        vecs[3] = '{32'h40000000, 32'h40400000, 5'd4,  32'h40C00000};
        vecs[4] = '{32'h3F800000, 32'h3F800000, 5'd31, 32'h3F800000};
        vecs[5] = '{32'h40000000, 32'h40000000, 5'd0,  32'h40800000};
        vecs[6] = '{32'h40400000, 32'h40400000, 5'd17, 32'h41100000};
        vecs[7] = '{32'h40800000, 32'h40000000, 5'd9,  32'h41000000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_issue_ready", 32'(issue_ready), 32'd0);
        check("rst_wb_valid",    32'(wb_valid),    32'd0);
        check("rst_mul_valid",   32'(mul_valid),   32'd0);
        check("rst_err",         32'(err),         32'd0);
        check("rst_wb_data",     wb_data,          32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(issue_ready), 32'd1);

        // Single op with latency
        wb_ready = 1'b1;
        wb_base = wbq.size();
        is_base = issue_cyc_q.size();
        issue_op(32'h40000000, 32'h40400000, 5'd5);
        wait_fires(wb_base + 1, 20);
        repeat (4) @(negedge clk);
        check("single_count", 32'(wbq.size() - wb_base), 32'd1);
        check_entry("single", wb_base, 5'd5, 32'h40C00000);
        if (fire_cyc_q.size() > wb_base && issue_cyc_q.size() > is_base)
            check("single_latency", 32'(fire_cyc_q[wb_base] - issue_cyc_q[is_base]), 32'(LAT + 2));
        else
            check("single_latency_missing", 32'd0, 32'd1);
        check("single_err", 32'(err), 32'd0);

        // Table: back-to-back issues, results in order
        wb_base = wbq.size();
        for (int i = 0; i < 8; i++) issue_op(vecs[i].a, vecs[i].b, vecs[i].rd);
        wait_fires(wb_base + 8, 60);
        for (int i = 0; i < 8; i++) check_entry($sformatf("vec%0d", i), wb_base + i, vecs[i].rd, vecs[i].exp);

        // Backpressure until credits are exhausted
        wb_ready = 1'b0;
        wb_base = wbq.size();
        is_base = issue_cyc_q.size();
        issue_op(32'h3F800000, 32'h3F800000, 5'd7);
        issue_op(32'h40000000, 32'h40000000, 5'd8);
        issue_op(32'h40400000, 32'h40400000, 5'd9);
        issue_op(32'h40800000, 32'h40000000, 5'd10);
        check("bp_ready_drop", 32'(issue_ready), 32'd0);
        issue_valid = 1'b1;
        issue_a     = 32'h40000000;
        issue_b     = 32'h40400000;
        issue_rd    = 5'd11;
        repeat (10) @(negedge clk);
        check("bp_ready_held", 32'(issue_ready), 32'd0);
        check("bp_wb_valid",   32'(wb_valid),    32'd1);
        check("bp_head_rd",    32'(wb_rd),       32'd7);
        check("bp_head_data",  wb_data,          32'h3F800000);
        check("bp_no_fire",    32'(wbq.size() - wb_base), 32'd0);
        check("bp_issues",     32'(issue_cyc_q.size() - is_base), 32'd4);

        // Credits at zero, issue pending, writeback opens
        wb_ready = 1'b1;
        @(negedge clk);
        check("sim_first_fire", 32'(wbq.size() - wb_base), 32'd1);
        check("sim_ready_back", 32'(issue_ready), 32'd1);
        @(negedge clk);
        issue_valid = 1'b0;
        check("sim_issue_count", 32'(issue_cyc_q.size() - is_base), 32'd5);
        if (issue_cyc_q.size() > is_base + 4 && fire_cyc_q.size() > wb_base)
            check("sim_issue_cycle", 32'(issue_cyc_q[is_base + 4] - fire_cyc_q[wb_base]), 32'd1);
        else
            check("sim_issue_missing", 32'd0, 32'd1);
        wait_fires(wb_base + 5, 40);
        check_entry("bp0", wb_base + 0, 5'd7,  32'h3F800000);
        check_entry("bp1", wb_base + 1, 5'd8,  32'h40800000);
        check_entry("bp2", wb_base + 2, 5'd9,  32'h41100000);
        check_entry("bp3", wb_base + 3, 5'd10, 32'h41000000);
        check_entry("bp4", wb_base + 4, 5'd11, 32'h40C00000);

        // Reset while three ops are in flight
        repeat (3) @(negedge clk);
        wb_base = wbq.size();
        for (int i = 0; i < 3; i++) issue_op(vecs[i].a, vecs[i].b, vecs[i].rd);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_rst_no_fire", 32'(wbq.size() - wb_base), 32'd0);
        check("mid_rst_credits", 32'(dut.r_credits), 32'(DEPTH));
        check("mid_rst_err",     32'(err),      32'd0);
        check("mid_rst_wb",      32'(wb_valid), 32'd0);
        issue_op(vecs[6].a, vecs[6].b, vecs[6].rd);
        wait_fires(wb_base + 1, 20);
        check_entry("post_rst", wb_base, vecs[6].rd, vecs[6].exp);

        // Result with no tag outstanding
        repeat (3) @(negedge clk);
        wb_base = wbq.size();
        force_ov = 1'b1;
        @(negedge clk);
        force_ov = 1'b0;
        check("err_set",      32'(err),      32'd1);
        check("err_wb_valid", 32'(wb_valid), 32'd0);
        repeat (5) @(negedge clk);
        check("err_sticky",   32'(err),      32'd1);
        check("err_no_fire",  32'(wbq.size() - wb_base), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_cleared",  32'(err),      32'd0);

        check("credit_range", 32'(cred_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fmul_wb_queue.md
Name: fmul_wb_queue

Overview:
- Sits between the FP instruction issue logic and the register-file writeback port, wrapped around the fmul pipeline.
- fmul is a fixed-latency pipeline with no backpressure and no tag pass-through.
- This block does four things:
  - accepts multiply requests on a valid/ready interface;
  - tracks each request's destination register in order;
  - captures every fmul result the cycle it appears;
  - holds results in a buffer until writeback accepts them.
- Credit-based admission guarantees a fmul result is never dropped.

Parameters:
- DEPTH, 4, maximum ops in flight plus buffered (power of two, 2..16).
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  request valid.
- issue_ready  out  1  request accepted when issue_valid && issue_ready.
- issue_a  in  32  operand A, IEEE-754 single.
- issue_b  in  32  operand B, IEEE-754 single.
- issue_rd  in  RD_W  destination register.
- mul_a  out  32  to fmul input_a.
- mul_b  out  32  to fmul input_b.
- mul_valid  out  1  to fmul input_valid.
- mul_result  in  32  from fmul result.
- mul_out_valid  in  1  from fmul out_valid.
- wb_valid  out  1  buffered result available.
- wb_ready  in  1  writeback consumes head when wb_valid && wb_ready.
- wb_rd  out  RD_W  destination of head entry.
- wb_data  out  32  result of head entry.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values (when rst=1 at a clock edge): all outputs 0, both FIFOs empty, credits=DEPTH.
  - issue_ready is 0 during reset and rises the first cycle after rst deasserts.
- fmul's rst_n is driven as ~rst by the parent, so fmul and this block flush together.
- Credit counter, range 0..DEPTH:
  - issue fire: decrement.
  - wb fire: increment.
  - both in the same cycle: unchanged.
  - issue_ready = (credits != 0). It is a registered-state function only; there is no combinational path from wb_ready or issue_valid.
- On issue fire:
  - mul_a, mul_b are registered from issue_a, issue_b; mul_valid=1 the next cycle, otherwise 0.
  - issue_rd is pushed into the tag FIFO the same cycle.
- On mul_out_valid (same cycle, combinational capture into FIFO write):
  - pop the tag FIFO head;
  - push {tag, mul_result} into the result FIFO.
  - Credits ensure the result FIFO is never full here.
- mul_out_valid with the tag FIFO empty: the result is dropped, err is set, and err stays set until rst.
- Result FIFO is show-ahead:
  - wb_valid = !empty;
  - wb_rd and wb_data reflect the head;
  - they must hold stable while wb_valid && !wb_ready.
- Simultaneous push and pop on the result FIFO (including at count 1):
  - both take effect;
  - count unchanged;
  - head advances to the next entry, or to the pushed entry if the FIFO was otherwise empty.
  - No bypass from mul_result directly to wb outputs: minimum latency from mul_out_valid to wb_valid is 1 cycle.
- End-to-end latency is 1 (issue register) + L_fmul + 1 (result FIFO) with wb_ready held high.
- Results leave in issue order.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; full/empty is tracked with a count register.
- Reset mid-operation: all in-flight tags, buffered results and credits are discarded; fmul is flushed simultaneously.
- Results are passed through unmodified. This block does no arithmetic on data and no NaN/Inf handling.

Decomposition:
- Package fpu_pkg holds:
  - RD_W default localparam;
  - typedef fwb_entry_t packed struct {logic [RD_W-1:0] rd; logic [31:0] data};
  - FP32 width constant.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; show-ahead; synchronous active-high reset; count output) is instantiated twice: the tag FIFO (WIDTH=RD_W) and the result FIFO (WIDTH=$bits(fwb_entry_t)).
- The credit counter and issue register live in the top module.

Test Plan:
- Single op: issue 2.0 (0x40000000) × 3.0 (0x40400000), rd=5, wb_ready=1 -> exactly one wb fire with wb_rd=5, wb_data=0x40C00000, L_fmul+2 cycles after issue; err=0.
- Ordering: back-to-back issues (1.5×1.5, rd=1), (-2.0×4.0, rd=2), (0.0×5.0, rd=3) -> wb in order:
  - rd=1 / 0x40100000;
  - rd=2 / 0xC1000000;
  - rd=3 / 0x00000000.
- Backpressure/full: wb_ready=0, issue_valid held with 4 distinct ops -> issue_ready drops the cycle after the 4th fire and stays 0. wb_valid=1 with head stable. Raising wb_ready drains all 4 in order; issue_ready returns to 1 the cycle after the first wb fire.
- Simultaneous: credits=0, an issue held pending, wb_ready=1 -> in the cycle one wb fire occurs, issue_ready is 1 the next cycle, then issue fires. Credits never exceed DEPTH or go below 0 (assertion).
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle before any result emerges -> no wb fire afterwards, credits=4, err=0. A new op issued after reset returns correctly.
- Error: force mul_out_valid=1 with no op issued -> err=1 next cycle and stays 1, wb_valid stays 0; rst clears err.
